// File: rtl/bitmanip_pkg.sv
// Shared types for the bit-manipulation sequencer: opcode and FSM encodings, CPOP iteration count
// and the per-chunk population count used by the iterative CPOP datapath.
package bitmanip_pkg;

  typedef enum logic [3:0] {
    OP_SLL  = 4'd0,
    OP_SRL  = 4'd1,
    OP_SRA  = 4'd2,
    OP_ROL  = 4'd3,
    OP_ROR  = 4'd4,
    OP_CLZ  = 4'd5,
    OP_CTZ  = 4'd6,
    OP_CPOP = 4'd7
  } op_code_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CPOP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int CPOP_ITER = 4;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/barrel_shifter_left.sv
// Log-stage left rotator: o_data = i_data rotated left by i_amt.
// Purely combinational; no flow control.
module barrel_shifter_left #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]         i_data,
  input  logic [$clog2(XLEN)-1:0] i_amt,
  output logic [XLEN-1:0]         o_data
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] w_stage [0:SW];

  assign w_stage[0] = i_data;

  for (genvar s = 0; s < SW; s++) begin : g_stage
    localparam int K = 1 << s;
    assign w_stage[s+1] = i_amt[s] ? {w_stage[s][XLEN-K-1:0], w_stage[s][XLEN-1:XLEN-K]} : w_stage[s];
  end

  assign o_data = w_stage[SW];

endmodule

// File: rtl/barrel_shifter_right.sv
// Log-stage right rotator: o_data = i_data rotated right by i_amt.
// Purely combinational; no flow control.
module barrel_shifter_right #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]         i_data,
  input  logic [$clog2(XLEN)-1:0] i_amt,
  output logic [XLEN-1:0]         o_data
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] w_stage [0:SW];

  assign w_stage[0] = i_data;

  for (genvar s = 0; s < SW; s++) begin : g_stage
    localparam int K = 1 << s;
    assign w_stage[s+1] = i_amt[s] ? {w_stage[s][K-1:0], w_stage[s][XLEN-1:K]} : w_stage[s];
  end

  assign o_data = w_stage[SW];

endmodule

// File: rtl/count_leading_zeros.sv
// Leading-zero counter; an all-zero input saturates at XLEN-1 because the count is only $clog2(XLEN) wide.
// Purely combinational; no flow control.
module count_leading_zeros #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]         i_data,
  output logic [$clog2(XLEN)-1:0] o_count
);

  localparam int CW = $clog2(XLEN);

  logic w_found;

  always_comb begin
    o_count = CW'(XLEN - 1);
    w_found = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (!w_found && i_data[i]) begin
        o_count = CW'(XLEN - 1 - i);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_trailing_zeros.sv
// Trailing-zero counter; an all-zero input saturates at XLEN-1 because the count is only $clog2(XLEN) wide.
// Purely combinational; no flow control.
module count_trailing_zeros #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]         i_data,
  output logic [$clog2(XLEN)-1:0] o_count
);

  localparam int CW = $clog2(XLEN);

  logic w_found;

  always_comb begin
    o_count = CW'(XLEN - 1);
    w_found = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      if (!w_found && i_data[i]) begin
        o_count = CW'(i);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bitmanip_sequencer.sv
// One-op-at-a-time shift/rotate/count sequencer: result_valid 2 cycles after accept (5 for CPOP).
// op_ready only in IDLE/DONE and never during flush or reset; flush aborts and drops the pending result.
module bitmanip_sequencer
  import bitmanip_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CPOP_CHUNK = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [3:0]              op_code,
  input  logic [XLEN-1:0]         op_a,
  input  logic [$clog2(XLEN)-1:0] op_b,
  input  logic                    op_flush,
  output logic                    busy,
  output logic                    result_valid,
  output logic [XLEN-1:0]         result,
  output logic                    illegal
);

  localparam int CW = $clog2(XLEN);
  localparam int AW = CW + 1;
  localparam int IW = $clog2(CPOP_ITER);

  state_e          r_state;
  state_e          w_state_nxt;
  logic            w_accept;
  logic [3:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [CW-1:0]   r_b;
  logic [IW-1:0]   r_cnt;
  logic [AW-1:0]   r_acc;
  logic [XLEN-1:0] r_result;
  logic            r_illegal;

  logic [XLEN-1:0]       w_rotr;
  logic [XLEN-1:0]       w_rotl;
  logic [CW-1:0]         w_clz;
  logic [CW-1:0]         w_ctz;
  logic [XLEN-1:0]       w_srl_mask;
  logic [XLEN-1:0]       w_sll_mask;
  logic [XLEN-1:0]       w_srl;
  logic [CPOP_CHUNK-1:0] w_chunk;
  logic [AW-1:0]         w_acc_nxt;
  logic                  w_cpop_last;
  logic [XLEN-1:0]       w_exec_result;
  logic                  w_exec_illegal;

  barrel_shifter_right #(.XLEN(XLEN)) u_rotr (.i_data(r_a), .i_amt(r_b), .o_data(w_rotr));
  barrel_shifter_left  #(.XLEN(XLEN)) u_rotl (.i_data(r_a), .i_amt(r_b), .o_data(w_rotl));
  count_leading_zeros  #(.XLEN(XLEN)) u_clz  (.i_data(r_a), .o_count(w_clz));
  count_trailing_zeros #(.XLEN(XLEN)) u_ctz  (.i_data(r_a), .o_count(w_ctz));

  assign w_srl_mask  = {XLEN{1'b1}} >> r_b;
  assign w_sll_mask  = {XLEN{1'b1}} << r_b;
  assign w_srl       = w_rotr & w_srl_mask;
  assign w_chunk     = r_a[int'(r_cnt) * CPOP_CHUNK +: CPOP_CHUNK];
  assign w_acc_nxt   = r_acc + AW'(popcount8(w_chunk));
  assign w_cpop_last = (r_cnt == IW'(CPOP_ITER - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    op_ready     = ((r_state == S_IDLE) || (r_state == S_DONE)) && !op_flush && reset;
    w_accept     = op_ready && op_valid;
    busy         = (r_state == S_EXEC) || (r_state == S_CPOP);
    result_valid = (r_state == S_DONE);
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_nxt = (op_code == OP_CPOP) ? S_CPOP : S_EXEC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC:  w_state_nxt = S_DONE;
      S_CPOP:  w_state_nxt = w_cpop_last ? S_DONE : S_CPOP;
      default: w_state_nxt = S_IDLE;
    endcase
    // Flush overrides everything, including a DONE-cycle accept.
    if (op_flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  // The counters saturate at XLEN-1 on zero input, so the true count of XLEN is patched in here.
  always_comb begin
    w_exec_result  = '0;
    w_exec_illegal = 1'b0;
    case (r_op)
      OP_SLL:  w_exec_result = w_rotl & w_sll_mask;
      OP_SRL:  w_exec_result = w_srl;
      OP_SRA:  w_exec_result = w_srl | (r_a[XLEN-1] ? ~w_srl_mask : '0);
      OP_ROL:  w_exec_result = w_rotl;
      OP_ROR:  w_exec_result = w_rotr;
      OP_CLZ:  w_exec_result = (r_a == '0) ? XLEN'(XLEN) : XLEN'(w_clz);
      OP_CTZ:  w_exec_result = (r_a == '0) ? XLEN'(XLEN) : XLEN'(w_ctz);
      OP_CPOP: w_exec_result = '0;
      default: w_exec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else if (op_flush) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= op_code;
        r_a   <= op_a;
        r_b   <= op_b;
        r_cnt <= '0;
        r_acc <= '0;
      end
      if (r_state == S_EXEC) begin
        r_result  <= w_exec_result;
        r_illegal <= w_exec_illegal;
      end
      if (r_state == S_CPOP) begin
        if (w_cpop_last) begin
          r_result  <= XLEN'(w_acc_nxt);
          r_illegal <= 1'b0;
        end else begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign result  = r_result;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_bitmanip_sequencer.sv
// Bench for bitmanip_sequencer: directed scenarios plus randomized ops scored against a plain-arithmetic model.
module tb_bitmanip_sequencer;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [3:0]  op_code;
  logic [31:0] op_a;
  logic [4:0]  op_b;
  logic        op_flush;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic        illegal;

  int tests_run;
  int tests_failed;

  bitmanip_sequencer #(.XLEN(32), .CPOP_CHUNK(8)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_flush(op_flush),
    .busy(busy), .result_valid(result_valid), .result(result), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [4:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    int n;
    r   = 32'd0;
    ill = 1'b0;
    lat = (op == 4'd7) ? 5 : 2;
    case (op)
      4'd0: r = a << b;
      4'd1: r = a >> b;
      4'd2: r = 32'($signed(a) >>> b);
      4'd3: r = (b == 0) ? a : ((a << b) | (a >> (32 - int'(b))));
      4'd4: r = (b == 0) ? a : ((a >> b) | (a << (32 - int'(b))));
      4'd5: begin
        n = 0;
        while (n < 32 && !a[31-n]) n++;
        r = 32'(n);
      end
      4'd6: begin
        n = 0;
        while (n < 32 && !a[n]) n++;
        r = 32'(n);
      end
      4'd7: r = 32'($countones(a));
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [4:0] b);
    op_valid = 1'b1;
    op_code  = op;
    op_a     = a;
    op_b     = b;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (result_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    tests_run++; if (op_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_op_ready got=%b exp=0", op_ready); end
    tests_run++; if (busy !== 1'b0 || result_valid !== 1'b0 || illegal !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags busy=%b valid=%b illegal=%b exp=000", busy, result_valid, illegal);
    end
    tests_run++; if (result !== 32'd0) begin tests_failed++; $display("FAIL reset_result got=%h exp=0", result); end
    reset = 1'b1;
    #1;
    tests_run++; if (op_ready !== 1'b1) begin tests_failed++; $display("FAIL post_reset_ready got=%b exp=1", op_ready); end
    tick();
  endtask

  task automatic test_sra();
    int cyc;
    drive_op(4'd2, 32'h80000010, 5'd4);
    wait_valid(cyc);
    tests_run++; if (cyc != 2) begin tests_failed++; $display("FAIL sra_latency got=%0d exp=2", cyc); end
    tests_run++; if (result !== 32'hF8000001 || illegal !== 1'b0) begin
      tests_failed++; $display("FAIL sra_result got=%h ill=%b exp=f8000001 ill=0", result, illegal);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [4] = '{4'd3, 4'd4, 4'd0, 4'd1};
    logic [31:0] as  [4] = '{32'h80000001, 32'h1, 32'h12345678, 32'hF0000000};
    logic [4:0]  bs  [4] = '{5'd1, 5'd1, 5'd0, 5'd28};
    logic [31:0] exp [4] = '{32'h3, 32'h80000000, 32'h12345678, 32'hF};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      drive_op(ops[i], as[i], bs[i]);
      wait_valid(cyc);
      tests_run++; if (cyc != 2) begin tests_failed++; $display("FAIL b2b_latency[%0d] got=%0d exp=2", i, cyc); end
      tests_run++; if (result !== exp[i]) begin tests_failed++; $display("FAIL b2b_result[%0d] got=%h exp=%h", i, result, exp[i]); end
      tests_run++; if (op_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_in_done[%0d] got=%b exp=1", i, op_ready); end
    end
    tick();
  endtask

  task automatic test_counts();
    logic [3:0]  ops [5] = '{4'd5, 4'd5, 4'd5, 4'd6, 4'd6};
    logic [31:0] as  [5] = '{32'h0, 32'h1, 32'h00010000, 32'h0, 32'h80000000};
    logic [31:0] exp [5] = '{32'd32, 32'd31, 32'd15, 32'd32, 32'd31};
    int cyc;
    for (int i = 0; i < 5; i++) begin
      drive_op(ops[i], as[i], 5'($urandom_range(31)));
      wait_valid(cyc);
      tests_run++; if (cyc != 2 || result !== exp[i]) begin
        tests_failed++; $display("FAIL count[%0d] lat=%0d got=%0d exp lat=2 val=%0d", i, cyc, result, exp[i]);
      end
      tick();
    end
  endtask

  task automatic test_cpop();
    drive_op(4'd7, 32'hFFFF0F01, 5'd0);
    for (int i = 1; i <= 4; i++) begin
      tests_run++; if (op_ready !== 1'b0 || busy !== 1'b1 || result_valid !== 1'b0) begin
        tests_failed++; $display("FAIL cpop_busy N+%0d ready=%b busy=%b valid=%b exp 0,1,0", i, op_ready, busy, result_valid);
      end
      tick();
    end
    tests_run++; if (result_valid !== 1'b1 || busy !== 1'b0 || result !== 32'd21) begin
      tests_failed++; $display("FAIL cpop_result valid=%b busy=%b got=%0d exp valid=1 busy=0 val=21", result_valid, busy, result);
    end
    tick();
    tests_run++; if (result_valid !== 1'b0) begin tests_failed++; $display("FAIL cpop_pulse_width valid=%b exp=0", result_valid); end
  endtask

  task automatic test_flush();
    int seen;
    drive_op(4'd7, $urandom, 5'd0);
    tick();
    op_valid = 1'b1;
    op_code  = 4'd0;
    op_flush = 1'b1;
    #1;
    tests_run++; if (op_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_ready_during got=%b exp=0", op_ready); end
    tick();
    op_valid = 1'b0;
    op_flush = 1'b0;
    #1;
    tests_run++; if (op_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL flush_after ready=%b busy=%b exp 1,0", op_ready, busy);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (result_valid === 1'b1) seen++;
      tick();
    end
    tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL flush_suppress valid_pulses=%0d exp=0", seen); end
    tests_run++; if (result !== 32'd21) begin tests_failed++; $display("FAIL flush_result_kept got=%0d exp=21", result); end
  endtask

  task automatic test_illegal();
    int cyc;
    drive_op(4'hF, 32'hDEADBEEF, 5'd3);
    wait_valid(cyc);
    tests_run++; if (cyc != 2 || result !== 32'd0 || illegal !== 1'b1) begin
      tests_failed++; $display("FAIL illegal lat=%0d got=%h ill=%b exp lat=2 val=0 ill=1", cyc, result, illegal);
    end
    drive_op(4'd0, 32'h0000ABCD, 5'd4);
    wait_valid(cyc);
    tests_run++; if (illegal !== 1'b0 || result !== 32'h000ABCD0) begin
      tests_failed++; $display("FAIL illegal_clear got=%h ill=%b exp=000abcd0 ill=0", result, illegal);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    drive_op(4'd1, 32'hFFFFFFFF, 5'd8);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    tests_run++; if (busy !== 1'b0 || result !== 32'd0 || illegal !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid busy=%b got=%h ill=%b exp 0,0,0", busy, result, illegal);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (result_valid === 1'b1) seen++;
      tick();
    end
    tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL reset_mid_valid pulses=%0d exp=0", seen); end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a;
    logic [4:0]  b;
    logic [31:0] exp_r;
    logic        exp_ill;
    int          exp_lat;
    int          cyc;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(7) == 0) ? 4'($urandom_range(15, 8)) : 4'($urandom_range(7));
      case ($urandom_range(3))
        0:       a = 32'd0;
        1:       a = 32'd1 << $urandom_range(31);
        default: a = $urandom;
      endcase
      b = 5'($urandom_range(31));
      model(op, a, b, exp_r, exp_ill, exp_lat);
      if ($urandom_range(1) == 1) tick();
      drive_op(op, a, b);
      wait_valid(cyc);
      tests_run++; if (cyc != exp_lat || result !== exp_r || illegal !== exp_ill) begin
        tests_failed++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%0d got lat=%0d r=%h ill=%b exp lat=%0d r=%h ill=%b",
                 i, op, a, b, cyc, result, illegal, exp_lat, exp_r, exp_ill);
      end
    end
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    op_valid     = 1'b0;
    op_code      = 4'd0;
    op_a         = 32'd0;
    op_b         = 5'd0;
    op_flush     = 1'b0;
    #1;
    test_reset();
    test_sra();
    test_back_to_back();
    test_counts();
    test_cpop();
    test_flush();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bitmanip_sequencer.md
Name: bitmanip_sequencer

Overview:
Multi-cycle controller for the shared rotate/count datapath: the right/left barrel rotators and the leading/trailing-zero counters. It accepts one bit-manipulation op at a time from the execute stage and registers the operands. It sequences the datapath, including a 4-cycle iterative population count, and returns a registered result with a one-cycle valid pulse. It sits beside the ALU in the execute stage and is flushed by the pipeline on redirect.

Parameters:
XLEN, 32, operand/result width (only 32 supported; count datapath sized by $clog2)
CPOP_CHUNK, 8, bits summed per CPOP iteration (CPOP iterations = XLEN/CPOP_CHUNK = 4)

Ports:
clk  input  1  single clock, all state on posedge
reset  input  1  synchronous, active-low: state cleared on posedge clk while reset==0
op_valid  input  1  request; accepted when op_valid & op_ready
op_ready  output  1  block can accept an op this cycle
op_code  input  4  0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5 CLZ, 6 CTZ, 7 CPOP, 8..15 illegal
op_a  input  32  data operand
op_b  input  5  shift/rotate amount (ignored for counts)
op_flush  input  1  abort current op, drop pending result
busy  output  1  op accepted, result not yet delivered
result_valid  output  1  one-cycle pulse, result valid
result  output  32  registered result, held until next completion
illegal  output  1  qualifies result_valid: opcode was illegal

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, result=0, result_valid=0, illegal=0, busy=0, CPOP counter/accumulator=0. op_ready=0 while reset is asserted.
- op_ready = (state==IDLE | state==DONE) & ~op_flush & reset.
- Accept: latch op_code/op_a/op_b. Next state is CPOP (cnt=0, acc=0) for op 7, else EXEC.
- EXEC (1 cycle): compute from the latched operands, register result, go to DONE.
- CPOP: each cycle acc += popcount(a[8*cnt +: 8]); cnt increments; at cnt==3 register result = acc + chunk, go to DONE.
- DONE: result_valid=1 for exactly this cycle. Without a new accept go to IDLE. A new accept in DONE is allowed (back-to-back).
- Latency: accept at cycle N gives result_valid at N+2 for ops 0-6 and illegal ops, and at N+5 for CPOP. Throughput is one op per 2 cycles (1 per 5 for CPOP).
- busy=1 from N+1 up to but not including the result_valid cycle.
- Arithmetic rules:
  - ROR/ROL come directly from the right/left rotators.
  - SRL = rotr(a,b) & (FFFFFFFF>>b).
  - SLL = rotl(a,b) & (FFFFFFFF<<b).
  - SRA = SRL | (a[31] ? ~(FFFFFFFF>>b) : 0).
  - b=0 returns a unchanged for all shifts and rotates.
- Zero input on CLZ/CTZ: the counters report 31 for a==0. The sequencer detects a==0 and returns 32. Otherwise result = {27'b0, count}.
- Illegal opcode: result=0, illegal=1 with result_valid. illegal clears on the next completion.
- Flush: op_flush==1 in any state forces IDLE next cycle, clears cnt/acc/busy and suppresses result_valid. result keeps its previous value. Flush wins over a simultaneous op_valid (no accept) and over a DONE-cycle accept. A flush in the DONE cycle itself does not retract that cycle's pulse.
- Reset mid-operation: identical to power-on reset, and no result_valid is produced.

Decomposition:
- bitmanip_pkg:
  - op_code enum with the 4-bit encodings above.
  - state enum IDLE/EXEC/CPOP/DONE.
  - CPOP_ITER constant.
  - popcount8 function.
- No new sub-module. Instantiate the existing barrel_shifter_right, barrel_shifter_left, count_leading_zeros and count_trailing_zeros on the latched operands. The FSM and the result mux stay in this module.

Test Plan:
1. SRA: a=0x80000010, b=4 accepted at N -> result_valid at N+2, result=0xF8000001, illegal=0.
2. Rotates/shifts back-to-back:
   - ROL a=0x80000001 b=1 -> 0x00000003.
   - ROR a=1 b=1 -> 0x80000000, accepted in the DONE cycle of the ROL.
   - SLL a=0x12345678 b=0 -> 0x12345678.
   - SRL a=0xF0000000 b=28 -> 0x0000000F.
3. Counts:
   - CLZ a=0 -> 32; a=1 -> 31; a=0x00010000 -> 15.
   - CTZ a=0 -> 32; a=0x80000000 -> 31.
4. CPOP a=0xFFFF0F01 accepted at N -> op_ready=0 and busy=1 during N+1..N+4; result_valid at N+5, result=21.
5. Flush mid-CPOP: accept at N, op_flush at N+2 with op_valid=1 -> no accept that cycle and no result_valid; op_ready=1 at N+3; result unchanged (21 from test 4).
6. Illegal and reset:
   - op_code=0xF -> result=0, illegal=1 at N+2.
   - reset=0 at N+1 of an SRL -> no result_valid; result=0, busy=0 after reset.
